// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_arbiter
// Description : Four-requester byte-stream TX arbiter with inter-frame gap
//               and forced truncation. Define TX_ARB_FIXED_PRIO_EN for fixed
//               priority (index 0 highest) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter #(
    parameter int IFG_TICKS = 12,
    parameter int MAX_LEN   = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_out_tick,
    input  logic [3:0]  i_req,
    input  logic [31:0] i_src_dat,
    input  logic [3:0]  i_src_last,
    output logic [3:0]  o_gnt,
    output logic [3:0]  o_src_ack,
    output logic [9:0]  o_out_eth_stream,
    output logic        o_busy,
    output logic        o_err_trunc
);

    localparam logic [10:0] C_LAST_IDX = 11'(MAX_LEN - 1);
    localparam logic [7:0]  C_GAP_LAST = 8'(IFG_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_gidx;
    logic [3:0]  r_gnt;
    logic [3:0]  r_ack;
    logic        r_cke;
    logic        r_frm;
    logic [7:0]  r_dat;
    logic        r_busy;
    logic        r_err;
    logic [10:0] r_cnt;
    logic [7:0]  r_gap;

    logic [1:0]  w_win;
    logic [7:0]  w_lane;
    logic        w_last;
    logic        w_req_g;

`ifdef TX_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (i_req[k]) w_win = 2'(k);
        end
    end
`else
    logic [1:0] r_ptr;
    logic [1:0] w_cand;

    // Scan from farthest to nearest so the index right after the pointer wins.
    always_comb begin
        w_win  = 2'd0;
        w_cand = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_cand = r_ptr + 2'(k + 1);
            if (i_req[w_cand]) w_win = w_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd3;
        end else if (r_state == S_ARB && |i_req) begin
            r_ptr <= w_win;
        end
    end
`endif

    assign w_lane  = i_src_dat[{r_gidx, 3'b000} +: 8];
    assign w_last  = i_src_last[r_gidx];
    assign w_req_g = i_req[r_gidx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gidx  <= 2'd0;
            r_gnt   <= 4'd0;
            r_ack   <= 4'd0;
            r_cke   <= 1'b0;
            r_frm   <= 1'b0;
            r_dat   <= 8'd0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 11'd0;
            r_gap   <= 8'd0;
        end else begin
            r_ack <= 4'd0;
            r_err <= 1'b0;
            r_cke <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_frm <= 1'b0;
                    if (|i_req) begin
                        r_state <= S_ARB;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARB: begin
                    r_frm <= 1'b0;
                    if (|i_req) begin
                        r_gidx  <= w_win;
                        r_gnt   <= 4'b0001 << w_win;
                        r_cnt   <= 11'd0;
                        r_state <= S_SEND;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_SEND: begin
                    // A withdrawn request aborts the frame without consuming a byte.
                    if (!w_req_g) begin
                        r_frm   <= 1'b0;
                        r_gnt   <= 4'd0;
                        r_err   <= 1'b1;
                        r_gap   <= 8'd0;
                        r_state <= S_GAP;
                    end else if (i_out_tick) begin
                        r_cke <= 1'b1;
                        r_frm <= 1'b1;
                        r_dat <= w_lane;
                        r_ack <= r_gnt;
                        r_cnt <= r_cnt + 11'd1;
                        if (w_last || r_cnt == C_LAST_IDX) begin
                            r_gnt   <= 4'd0;
                            r_gap   <= 8'd0;
                            r_err   <= !w_last;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    r_frm <= 1'b0;
                    if (i_out_tick) begin
                        if (r_gap == C_GAP_LAST) begin
                            r_gap   <= 8'd0;
                            r_state <= S_ARB;
                        end else begin
                            r_gap <= r_gap + 8'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_gnt            = r_gnt;
    assign o_src_ack        = r_ack;
    assign o_out_eth_stream = {r_cke, r_frm, r_dat};
    assign o_busy           = r_busy;
    assign o_err_trunc      = r_err;

endmodule
`default_nettype wire
